// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder unit: radix-2 restoring divider with sign fix-up,
// one quotient bit per cycle, Moore BUSY/DONE outputs decoded from the registered state.
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             KILL,
    input  logic [1:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FIX    = 2'd2,
        DONE_S = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             in_signed;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_sub;
    logic             fits;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Conditioning of the request presented on the inputs this cycle
    always_comb begin
        in_signed = ~SELECT[0];
        div_zero  = (DATA2 == '0);
        overflow  = in_signed && (DATA1 == MIN_NEG) && (DATA2 == '1);
        a_abs     = (in_signed && DATA1[WIDTH-1]) ? -DATA1 : DATA1;
        b_abs     = (in_signed && DATA2[WIDTH-1]) ? -DATA2 : DATA2;
    end

    // One restoring step; the partial remainder is always below the divisor,
    // so the low WIDTH bits of the difference are exact whenever it fits.
    always_comb begin
        shifted = {rem_q, dvd_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs_q});
        rem_sub = shifted[WIDTH-1:0] - dvs_q;
        q_fix   = (~sel_q[0] && qneg_q) ? -dvd_q : dvd_q;
        r_fix   = (~sel_q[0] && rneg_q) ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;

        if (KILL) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE_S: begin
                    if (START) begin
                        sel_d  = SELECT;
                        dvd_d  = a_abs;
                        dvs_d  = b_abs;
                        qneg_d = DATA1[WIDTH-1] ^ DATA2[WIDTH-1];
                        rneg_d = DATA1[WIDTH-1];
                        rem_d  = '0;
                        cnt_d  = CNT_W'(WIDTH - 1);
                        if (div_zero) begin
                            result_d = SELECT[1] ? DATA1 : '1;
                            state_d  = DONE_S;
                        end else if (overflow) begin
                            result_d = SELECT[1] ? '0 : MIN_NEG;
                            state_d  = DONE_S;
                        end else begin
                            state_d = CALC;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    rem_d = fits ? rem_sub : shifted[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], fits};
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    result_d = sel_q[1] ? r_fix : q_fix;
                    state_d  = DONE_S;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign RESULT    = result_q;
    assign BUSY      = (state_q == CALC) || (state_q == FIX);
    assign DONE      = (state_q == DONE_S);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed literal cases plus random traffic, all checked
// every cycle against an arithmetic reference of what the unit must report.
module tb_div_sequencer;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;
  localparam int NORM_LAT = W + 1;

  logic         CLK;
  logic         RESET;
  logic         START;
  logic         KILL;
  logic [1:0]   SELECT;
  logic [W-1:0] DATA1;
  logic [W-1:0] DATA2;
  logic [W-1:0] RESULT;
  logic         BUSY;
  logic         DONE;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  div_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .KILL(KILL), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference arithmetic (RISC-V M semantics)
  function automatic logic is_special(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) || (!sel[0] && a == MIN_NEG && b == '1);
  endfunction

  function automatic logic [W-1:0] ref_op(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!sel[0] && a == MIN_NEG && b == '1) begin
      q = MIN_NEG;
      r = '0;
    end else if (!sel[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return sel[1] ? r : q;
  endfunction

  // behavioural timing model: an op is in flight for W+1 edges unless special
  logic         m_inflight = 1'b0;
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_pend = '0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_inflight <= 1'b0;
      m_left     <= 0;
      m_done     <= 1'b0;
      m_result   <= '0;
      m_pend     <= '0;
    end else begin
      m_done <= 1'b0;
      if (KILL) begin
        m_inflight <= 1'b0;
      end else if (m_inflight) begin
        if (m_left == 1) begin
          m_inflight <= 1'b0;
          m_done     <= 1'b1;
          m_result   <= m_pend;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (START) begin
        if (is_special(SELECT, DATA1, DATA2)) begin
          m_result <= ref_op(SELECT, DATA1, DATA2);
          m_done   <= 1'b1;
        end else begin
          m_inflight <= 1'b1;
          m_left     <= NORM_LAT;
          m_pend     <= ref_op(SELECT, DATA1, DATA2);
        end
      end
    end
  end

  // scoreboard: expected queue holds the next result the model will present
  logic [W-1:0] exp_q[$];

  always @(negedge CLK) begin
    if (RESET) begin
      check("busy", {31'b0, BUSY}, {31'b0, m_inflight});
      check("done", {31'b0, DONE}, {31'b0, m_done});
      check("result", RESULT, m_result);
      if (m_done) begin
        exp_q.push_back(m_result);
        check("result_on_done", RESULT, exp_q.pop_front());
      end
    end
  end

  // driver tasks (called at a falling edge)
  task automatic drive_start(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    START  = 1'b1;
    SELECT = sel;
    DATA1  = a;
    DATA2  = b;
    @(negedge CLK);
    START = 1'b0;
    DATA1 = $urandom;
    DATA2 = $urandom;
    SELECT = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!DONE && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_lat);
    int lat;
    @(negedge CLK);
    drive_start(sel, a, b);
    wait_done(lat);
    check({name, "_lat"}, W'(lat), W'(exp_lat));
    check({name, "_res"}, RESULT, exp_res);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return MIN_NEG;
      2: return '1;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, lat2;
    logic done_seen;
    RESET = 1'b0; START = 1'b0; KILL = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
    repeat (3) @(negedge CLK);
    check("rst_result", RESULT, '0);
    check("rst_busy", {31'b0, BUSY}, '0);
    check("rst_done", {31'b0, DONE}, '0);
    RESET = 1'b1;

    // pin the reference model itself
    check("model_divu", ref_op(2'b01, 32'd100, 32'd7), 32'd14);
    check("model_div_neg", ref_op(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_rem_neg", ref_op(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, NORM_LAT);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, NORM_LAT);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORM_LAT);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORM_LAT);
    run_op("divu_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, NORM_LAT);
    run_op("div_ovf", 2'b00, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 0);
    run_op("rem_ovf", 2'b10, MIN_NEG, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("divu_ovf_ops", 2'b01, MIN_NEG, 32'hFFFF_FFFF, 32'd0, NORM_LAT);
    run_op("div_by0", 2'b00, 32'h1234, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remu_by0", 2'b11, 32'h1234, 32'd0, 32'h1234, 0);

    // KILL at edge N+10
    @(negedge CLK);
    drive_start(2'b01, 32'd100, 32'd7);
    repeat (9) @(negedge CLK);
    KILL = 1'b1;
    @(negedge CLK);
    KILL = 1'b0;
    check("kill_busy", {31'b0, BUSY}, '0);
    check("kill_result", RESULT, 32'h1234);
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      done_seen |= DONE;
    end
    check("kill_no_done", {31'b0, done_seen}, '0);

    // back-to-back start in the DONE cycle
    @(negedge CLK);
    drive_start(2'b01, 32'd1000, 32'd10);
    wait_done(lat);
    check("b2b_first", RESULT, 32'd100);
    drive_start(2'b11, 32'd1000, 32'd7);
    wait_done(lat);
    check("b2b_second_lat", W'(lat), W'(NORM_LAT));
    check("b2b_second", RESULT, 32'd6);

    // START while busy is ignored
    @(negedge CLK);
    drive_start(2'b01, 32'd100, 32'd7);
    repeat (4) @(negedge CLK);
    START = 1'b1; SELECT = 2'b01; DATA1 = 32'd50; DATA2 = 32'd5;
    @(negedge CLK);
    START = 1'b0;
    wait_done(lat2);
    check("busy_start_lat", W'(lat2 + 5), W'(NORM_LAT));
    check("busy_start_res", RESULT, 32'd14);

    // asynchronous reset between edges mid-CALC
    @(negedge CLK);
    drive_start(2'b00, 32'd12345, 32'd17);
    repeat (8) @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check("async_rst_busy", {31'b0, BUSY}, '0);
    check("async_rst_result", RESULT, '0);
    check("async_rst_done", {31'b0, DONE}, '0);
    @(negedge CLK);
    RESET = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      done_seen |= DONE;
    end
    check("async_rst_no_done", {31'b0, done_seen}, '0);

    // random traffic, including starts while busy, back-to-back and kills
    repeat (6000) begin
      @(negedge CLK);
      START  = ($urandom_range(0, 7) == 0);
      KILL   = ($urandom_range(0, 59) == 0);
      SELECT = 2'($urandom_range(0, 3));
      DATA1  = rand_operand();
      DATA2  = rand_operand();
    end
    @(negedge CLK);
    START = 1'b0;
    KILL  = 1'b0;
    repeat (40) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
